// File: rtl/lsu_req_queue.sv
// In-order load/store request queue feeding the 16-bit LSU.
// Slots are allocated at tail, handed to the LSU at iss, and freed at ret, all in program order.
module lsu_req_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             enq_valid,
  input  logic [15:0]      enq_addr,
  input  logic [15:0]      enq_data,
  input  logic             enq_width,
  input  logic             enq_cmd,
  output logic             enq_ready,
  output logic [TAG_W-1:0] enq_tag,
  output logic [15:0]      rq_addr,
  output logic [15:0]      rq_data,
  output logic             rq_width,
  output logic             rq_cmd,
  output logic [TAG_W-1:0] rq_tag,
  output logic             rq_start,
  input  logic             rq_hold,
  input  logic             rs_wb,
  input  logic [TAG_W-1:0] rs_tag,
  output logic             q_empty,
  output logic [TAG_W:0]   q_count,
  output logic             tag_err
);

  localparam int PW = TAG_W + 1;

  // Handshakes: an enqueue happens on any rising edge where enq_valid & enq_ready;
  // enq_ready never looks at enq_valid. An issue happens on every edge where rq_start
  // is high; rq_start is only raised while rq_hold is low, so the LSU never sees a
  // strobe it cannot take.

  logic [PW-1:0]    tail_q, tail_d;
  logic [PW-1:0]    iss_q, iss_d;
  logic [PW-1:0]    ret_q, ret_d;
  logic             tag_err_q, tag_err_d;

  logic [15:0]      addr_q  [DEPTH];
  logic [15:0]      data_q  [DEPTH];
  logic             width_q [DEPTH];
  logic             cmd_q   [DEPTH];

  logic [TAG_W-1:0] tail_slot;
  logic [TAG_W-1:0] iss_slot;
  logic [TAG_W-1:0] ret_slot;
  logic [PW-1:0]    count;
  logic             full;
  logic             enq_fire;
  logic             pending;
  logic             issued;
  logic             ret_is_store;
  logic             wb_match;
  logic             retire;

  assign tail_slot = tail_q[TAG_W-1:0];
  assign iss_slot  = iss_q[TAG_W-1:0];
  assign ret_slot  = ret_q[TAG_W-1:0];

  // Extra pointer bit distinguishes full from empty when the slot indices coincide.
  assign count    = tail_q - ret_q;
  assign full     = (count == PW'(DEPTH));
  assign enq_fire = enq_valid & ~full;

  assign pending  = (iss_q != tail_q);
  assign issued   = (ret_q != iss_q);

  assign ret_is_store = cmd_q[ret_slot];
  assign wb_match     = rs_wb & issued & ~ret_is_store & (rs_tag == ret_slot);
  assign retire       = issued & (ret_is_store | wb_match);

  assign enq_ready = ~full;
  assign enq_tag   = tail_slot;
  assign q_empty   = (count == '0);
  assign q_count   = count;
  assign tag_err   = tag_err_q;

  assign rq_start  = pending & ~rq_hold;
  assign rq_tag    = iss_slot;
  assign rq_addr   = addr_q[iss_slot];
  assign rq_data   = data_q[iss_slot];
  assign rq_width  = width_q[iss_slot];
  assign rq_cmd    = cmd_q[iss_slot];

  always_comb begin
    tail_d    = tail_q;
    iss_d     = iss_q;
    ret_d     = ret_q;
    tag_err_d = tag_err_q;
    if (enq_fire) tail_d = tail_q + PW'(1);
    if (rq_start) iss_d = iss_q + PW'(1);
    if (retire)   ret_d = ret_q + PW'(1);
    // A write-back that does not name the oldest issued load is dropped but remembered.
    if (rs_wb && !wb_match) tag_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      tail_q    <= '0;
      iss_q     <= '0;
      ret_q     <= '0;
      tag_err_q <= 1'b0;
    end else begin
      tail_q    <= tail_d;
      iss_q     <= iss_d;
      ret_q     <= ret_d;
      tag_err_q <= tag_err_d;
    end
  end

  // Payload storage is not reset; nothing reads a slot before it has been written.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      addr_q[tail_slot]  <= enq_addr;
      data_q[tail_slot]  <= enq_data;
      width_q[tail_slot] <= enq_width;
      cmd_q[tail_slot]   <= enq_cmd;
    end
  end

endmodule

// File: tb/tb_lsu_req_queue.sv
// Bench for lsu_req_queue: directed scenarios plus random traffic, all checked every
// cycle against a queue-of-ops reference model.
module tb_lsu_req_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 2;

  logic             clk;
  logic             a_rst;
  logic             enq_valid;
  logic [15:0]      enq_addr;
  logic [15:0]      enq_data;
  logic             enq_width;
  logic             enq_cmd;
  logic             enq_ready;
  logic [TAG_W-1:0] enq_tag;
  logic [15:0]      rq_addr;
  logic [15:0]      rq_data;
  logic             rq_width;
  logic             rq_cmd;
  logic [TAG_W-1:0] rq_tag;
  logic             rq_start;
  logic             rq_hold;
  logic             rs_wb;
  logic [TAG_W-1:0] rs_tag;
  logic             q_empty;
  logic [TAG_W:0]   q_count;
  logic             tag_err;

  lsu_req_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .a_rst(a_rst),
    .enq_valid(enq_valid), .enq_addr(enq_addr), .enq_data(enq_data),
    .enq_width(enq_width), .enq_cmd(enq_cmd), .enq_ready(enq_ready), .enq_tag(enq_tag),
    .rq_addr(rq_addr), .rq_data(rq_data), .rq_width(rq_width), .rq_cmd(rq_cmd),
    .rq_tag(rq_tag), .rq_start(rq_start), .rq_hold(rq_hold),
    .rs_wb(rs_wb), .rs_tag(rs_tag),
    .q_empty(q_empty), .q_count(q_count), .tag_err(tag_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        width;
    logic        cmd;
    logic [1:0]  tag;
  } op_t;

  op_t        mq[$];       // allocated ops, oldest first
  int         n_iss;       // how many of mq (from the front) have been issued
  int         enq_total;   // ops accepted since reset; tag = enq_total mod DEPTH
  bit         m_tag_err;
  bit         prev_start;
  logic [1:0] prev_tag;
  logic [1:0] issued_tags[$];

  task automatic model_reset();
    mq.delete();
    issued_tags.delete();
    n_iss = 0;
    enq_total = 0;
    m_tag_err = 0;
    prev_start = 0;
    prev_tag = '0;
  endtask

  // Compare every output against the model for the current inputs, then advance the model.
  task automatic model_step();
    int         cnt;
    bit         pend;
    bit         exp_start;
    logic [1:0] exp_rq_tag;
    bit         wb_ok;
    bit         ret_now;
    op_t        op;
    cnt        = mq.size();
    pend       = (n_iss < cnt);
    exp_start  = pend && !rq_hold;
    exp_rq_tag = pend ? mq[n_iss].tag : 2'(enq_total % DEPTH);

    check_eq("enq_ready", 32'(enq_ready), 32'(cnt < DEPTH));
    check_eq("enq_tag",   32'(enq_tag),   32'(enq_total % DEPTH));
    check_eq("q_count",   32'(q_count),   32'(cnt));
    check_eq("q_empty",   32'(q_empty),   32'(cnt == 0));
    check_eq("rq_start",  32'(rq_start),  32'(exp_start));
    check_eq("rq_tag",    32'(rq_tag),    32'(exp_rq_tag));
    check_eq("tag_err",   32'(tag_err),   32'(m_tag_err));
    if (pend) begin
      check_eq("rq_addr",  32'(rq_addr),  32'(mq[n_iss].addr));
      check_eq("rq_data",  32'(rq_data),  32'(mq[n_iss].data));
      check_eq("rq_width", 32'(rq_width), 32'(mq[n_iss].width));
      check_eq("rq_cmd",   32'(rq_cmd),   32'(mq[n_iss].cmd));
    end

    wb_ok   = rs_wb && (n_iss > 0) && (mq[0].cmd == 1'b0) && (rs_tag == mq[0].tag);
    ret_now = (n_iss > 0) && ((mq[0].cmd == 1'b1) || wb_ok);
    if (rs_wb && !wb_ok) m_tag_err = 1;

    prev_start = exp_start;
    prev_tag   = exp_rq_tag;
    if (exp_start) issued_tags.push_back(exp_rq_tag);
    if (ret_now) begin
      void'(mq.pop_front());
      n_iss--;
    end
    if (exp_start) n_iss++;
    if (enq_valid && cnt < DEPTH) begin
      op.addr  = enq_addr;
      op.data  = enq_data;
      op.width = enq_width;
      op.cmd   = enq_cmd;
      op.tag   = 2'(enq_total % DEPTH);
      mq.push_back(op);
      enq_total++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enq_valid = 0; enq_addr = '0; enq_data = '0; enq_width = 0; enq_cmd = 0;
    rq_hold = 0; rs_wb = 0; rs_tag = '0;
  endtask

  task automatic set_enq(input logic v, input logic [15:0] a, input logic [15:0] d,
                         input logic w, input logic c);
    enq_valid = v; enq_addr = a; enq_data = d; enq_width = w; enq_cmd = c;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_enq_ready"}, 32'(enq_ready), 32'd1);
    check_eq({tag, "_enq_tag"},   32'(enq_tag),   32'd0);
    check_eq({tag, "_rq_start"},  32'(rq_start),  32'd0);
    check_eq({tag, "_rq_tag"},    32'(rq_tag),    32'd0);
    check_eq({tag, "_q_empty"},   32'(q_empty),   32'd1);
    check_eq({tag, "_q_count"},   32'(q_count),   32'd0);
    check_eq({tag, "_tag_err"},   32'(tag_err),   32'd0);
  endtask

  // Asserts a_rst between edges so its asynchronous effect is visible before any clock.
  task automatic do_reset(input string tag);
    idle_inputs();
    a_rst = 0;
    #1;
    check_reset_outputs(tag);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    a_rst = 1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    a_rst = 1;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    do_reset("por");

    // Single load: issue the cycle after enqueue, retire on its write-back.
    set_enq(1, 16'h1234, 16'h0, 0, 0);
    check_eq("load0_enq_tag", 32'(enq_tag), 32'd0);
    tick();
    set_enq(0, 16'h0, 16'h0, 0, 0);
    check_eq("load0_start", 32'(rq_start), 32'd1);
    check_eq("load0_addr", 32'(rq_addr), 32'h1234);
    check_eq("load0_tag", 32'(rq_tag), 32'd0);
    tick();
    rs_wb = 1; rs_tag = 2'd0;
    tick();
    rs_wb = 0;
    check_eq("load0_count", 32'(q_count), 32'd0);
    tick();

    // Fill with rq_hold high, then release: tags issue in order.
    do_reset("r_fill");
    rq_hold = 1;
    for (int i = 0; i < 4; i++) begin
      set_enq(1, 16'(16'h0100 + i), 16'(i), 0, 0);
      tick();
    end
    set_enq(1, 16'hdead, 16'h0, 0, 0);
    check_eq("fill_count", 32'(q_count), 32'd4);
    check_eq("fill_ready", 32'(enq_ready), 32'd0);
    check_eq("fill_start", 32'(rq_start), 32'd0);
    tick();
    set_enq(0, 16'h0, 16'h0, 0, 0);
    rq_hold = 0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("fill_ntags", 32'(issued_tags.size()), 32'd4);
    for (int i = 0; i < 4 && i < issued_tags.size(); i++)
      check_eq("fill_tag_order", 32'(issued_tags[i]), 32'(i));
    // Full with a retiring write-back: the concurrent enqueue must still be refused.
    set_enq(1, 16'hbeef, 16'h0, 0, 0);
    rs_wb = 1; rs_tag = 2'd0;
    tick();
    set_enq(0, 16'h0, 16'h0, 0, 0);
    rs_wb = 0;
    check_eq("full_wb_ready", 32'(enq_ready), 32'd1);
    check_eq("full_wb_count", 32'(q_count), 32'd3);
    for (int i = 1; i < 4; i++) begin
      rs_wb = 1; rs_tag = 2'(i);
      tick();
    end
    rs_wb = 0;
    check_eq("full_drain_count", 32'(q_count), 32'd0);
    check_eq("full_drain_err", 32'(tag_err), 32'd0);
    tick();

    // Two stores issue back to back and retire without any write-back.
    do_reset("r_store");
    set_enq(1, 16'h0010, 16'haaaa, 1, 1);
    tick();
    check_eq("st0_start", 32'(rq_start), 32'd1);
    check_eq("st0_addr", 32'(rq_addr), 32'h0010);
    set_enq(1, 16'h0011, 16'h5555, 1, 1);
    tick();
    set_enq(0, 16'h0, 16'h0, 0, 0);
    check_eq("st1_start", 32'(rq_start), 32'd1);
    check_eq("st1_addr", 32'(rq_addr), 32'h0011);
    tick();
    check_eq("st_count_1", 32'(q_count), 32'd1);
    tick();
    check_eq("st_count_0", 32'(q_count), 32'd0);
    tick();

    // Ten loads streamed through, each written back one cycle after issue.
    do_reset("r_wrap");
    for (int cyc = 0; cyc < 40 && !(enq_total == 10 && mq.size() == 0); cyc++) begin
      set_enq(enq_total < 10, 16'(16'h2000 + enq_total), 16'h0, 0, 0);
      rs_wb = prev_start; rs_tag = prev_tag;
      tick();
    end
    idle_inputs();
    check_eq("wrap_ntags", 32'(issued_tags.size()), 32'd10);
    for (int i = 0; i < issued_tags.size(); i++)
      check_eq("wrap_tag_order", 32'(issued_tags[i]), 32'(i % 4));
    check_eq("wrap_tag_err", 32'(tag_err), 32'd0);
    tick();

    // Wrong-tag write-back is flagged and ignored; the right one then retires.
    do_reset("r_mismatch");
    for (int i = 0; i < 3; i++) begin
      set_enq(1, 16'(16'h3000 + i), 16'h0, 0, 0);
      rs_wb = prev_start; rs_tag = prev_tag;
      tick();
    end
    set_enq(0, 16'h0, 16'h0, 0, 0);
    rs_wb = prev_start; rs_tag = prev_tag;
    tick();
    check_eq("mm_outstanding", 32'(q_count), 32'd1);
    rs_wb = 1; rs_tag = 2'd3;
    tick();
    check_eq("mm_err_set", 32'(tag_err), 32'd1);
    check_eq("mm_no_retire", 32'(q_count), 32'd1);
    rs_wb = 1; rs_tag = 2'd2;
    tick();
    rs_wb = 0;
    check_eq("mm_retired", 32'(q_count), 32'd0);
    check_eq("mm_err_sticky", 32'(tag_err), 32'd1);
    tick();

    // Random traffic, mostly legal write-backs, occasional stray ones.
    do_reset("r_rand");
    for (int cyc = 0; cyc < 600; cyc++) begin
      set_enq(($urandom_range(0, 99) < 60), 16'($urandom), 16'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      rq_hold = ($urandom_range(0, 99) < 30);
      rs_wb = 0; rs_tag = 2'($urandom_range(0, 3));
      if (n_iss > 0 && mq[0].cmd == 1'b0 && $urandom_range(0, 99) < 50) begin
        rs_wb = 1; rs_tag = mq[0].tag;
      end else if ($urandom_range(0, 99) < 2) begin
        rs_wb = 1;
      end
      tick();
      if (cyc == 300) do_reset("r_mid");
    end

    // Reset in the middle of a busy stream.
    rq_hold = 1;
    for (int i = 0; i < 3; i++) begin
      set_enq(1, 16'($urandom), 16'($urandom), 0, 0);
      tick();
    end
    rs_wb = 1; rs_tag = 2'd3;
    tick();
    do_reset("r_final");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
